rom_arbiter: RTL
================

# rom_arbiter

Two-port arbiter that shares the single-port instruction ROM between the CPU instruction-fetch port and a data-read port (loads from the read-only code/constant region). It converts byte addresses to ROM word addresses, rejects misaligned and out-of-range requests with an error response, drives the ROM read strobe, and routes the 1-cycle-latency ROM output back to the requester that owns it. Round-robin arbitration guarantees neither port starves.

## Interface
- ADDR_WIDTH, 13, ROM word-address width (ROM depth 2**ADDR_WIDTH words)
- DATA_WIDTH, 32, ROM word width

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  instruction-fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch response valid (1-cycle pulse)
- if_rdata  out  DATA_WIDTH  fetch data, valid when if_rvalid
- if_err  out  1  fetch response is an error, qualified by if_rvalid
- dr_req, dr_addr, dr_gnt, dr_rvalid, dr_rdata, dr_err: same as if_* for the data-read port
- rom_rd  out  1  ROM read strobe
- rom_addr  out  ADDR_WIDTH  ROM word address
- rom_dout  in  DATA_WIDTH  ROM registered output, valid the cycle after rom_rd

## Operation
- Arbitration (combinational, every cycle, rst low):
  - only one port requesting -> that port granted
  - both requesting -> grant port not granted last; last_grant register updated on every grant
  - reset value of last_grant = data port, so first tie goes to fetch
- At most one grant per cycle; grant cycle N = accept cycle.
- Address check on granted address A:
  - misaligned: A[1:0] != 0
  - out of range: A[31:ADDR_WIDTH+2] != 0
  - either -> error access: rom_rd = 0 in cycle N, err response in N+1
  - otherwise -> rom_rd = 1, rom_addr = A[ADDR_WIDTH+1:2] in cycle N
- When no valid access, rom_rd = 0, rom_addr = 0.
- Response state (registered at end of N): resp_owner (IF/DR), resp_err, resp_pending.
- FSM states: IDLE (no pending response), RESP (response presented this cycle).
  - IDLE -> RESP on any grant
  - RESP -> RESP on grant this cycle (back-to-back), else -> IDLE
- In RESP: owner's rvalid = 1; owner's rdata = rom_dout if !resp_err else 0; err = resp_err. Non-owner rvalid = 0, rdata = 0, err = 0.
- rdata is 0 whenever the port's rvalid is 0.
- No response backpressure: requester must accept rvalid pulse; response is never repeated.
- Error accesses count as grants for round-robin rotation.

## Timing
- Latency: grant cycle N -> rvalid cycle N+1, for good and error accesses alike.
- Throughput: one access per cycle; sustained alternation under contention (IF, DR, IF, ...).
- Starvation bound: a held request is granted within 2 cycles.
- Reset (rst high at a rising edge): next cycle resp_pending = 0, state IDLE, last_grant = data; all rvalid/err = 0, rdata = 0. While rst high: if_gnt = dr_gnt = 0, rom_rd = 0.
- Reset mid-operation: access granted in the cycle reset is asserted produces no response; a grant in cycle N with rst in N+1 also produces no response (outputs forced to reset values while rst high).
- Requester dropping req before gnt: legal, no access occurs.
- Same-cycle grant and response: a port may receive rvalid for the previous access and gnt for a new one in the same cycle.

## Test plan
- Single fetch: if_req, if_addr=0x0000_0010, ROM word 4 = 0xDEADBEEF -> if_gnt cycle N with rom_rd=1, rom_addr=4; if_rvalid=1, if_rdata=0xDEADBEEF, if_err=0 at N+1; dr_* stay 0.
- Contention: both ports request continuously from reset, if_addr=0x0, dr_addr=0x4 -> grants IF,DR,IF,DR; each rvalid one cycle after its grant with words 0 and 1; never two grants in one cycle.
- Misaligned: dr_addr=0x0000_0006 -> dr_gnt=1, rom_rd=0; next cycle dr_rvalid=1, dr_err=1, dr_rdata=0.
- Out of range (ADDR_WIDTH=13): if_addr=0x0000_8000 -> if_err=1 next cycle, rom_rd never asserted; if_addr=0x0000_7FFC -> rom_addr=0x1FFF, if_err=0.
- Back-to-back: fetch 0x0,0x4,0x8 on consecutive cycles -> if_rvalid high 3 consecutive cycles, data words 0,1,2 in order.
- Reset mid-operation: grant at N, rst high at N+1 -> no rvalid at N+1, no grants while rst high; after release, first tie grants fetch.

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares a single-port instruction ROM between the instruction
// fetch port (if_*) and the data-read port (dr_*). Round-robin arbitration,
// byte-to-word address conversion, error responses for misaligned or
// out-of-range addresses, and routing of the 1-cycle-latency ROM output.
module rom_arbiter #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  dr_req,
  input  logic [31:0]           dr_addr,
  output logic                  dr_gnt,
  output logic                  dr_rvalid,
  output logic [DATA_WIDTH-1:0] dr_rdata,
  output logic                  dr_err,
  output logic                  rom_rd,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout
);

  typedef enum logic {IDLE, RESP} state_e;
  typedef enum logic {PORT_IF, PORT_DR} port_e;

  state_e state_q, state_d;
  port_e  last_grant_q, last_grant_d;
  port_e  resp_owner_q, resp_owner_d;
  logic   resp_err_q, resp_err_d;

  logic        any_gnt;
  logic        addr_ok;
  logic [31:0] sel_addr;
  logic        resp_valid;

  // Round-robin grant; a tie goes to the port not granted last
  always_comb begin
    if_gnt = 1'b0;
    dr_gnt = 1'b0;
    if (!rst) begin
      if (if_req && dr_req) begin
        if (last_grant_q == PORT_DR) if_gnt = 1'b1;
        else                         dr_gnt = 1'b1;
      end else begin
        if_gnt = if_req;
        dr_gnt = dr_req;
      end
    end
  end

  // Address check on the granted request and ROM strobe generation
  always_comb begin
    any_gnt  = if_gnt | dr_gnt;
    sel_addr = dr_gnt ? dr_addr : if_addr;
    addr_ok  = (sel_addr[1:0] == 2'b00) && (sel_addr[31:ADDR_WIDTH+2] == '0);
    rom_rd   = any_gnt && addr_ok;
    rom_addr = rom_rd ? sel_addr[ADDR_WIDTH+1:2] : '0;
  end

  // Next-state: every grant (good or error) opens a response next cycle
  always_comb begin
    state_d      = IDLE;
    last_grant_d = last_grant_q;
    resp_owner_d = resp_owner_q;
    resp_err_d   = resp_err_q;
    if (any_gnt) begin
      state_d      = RESP;
      last_grant_d = dr_gnt ? PORT_DR : PORT_IF;
      resp_owner_d = dr_gnt ? PORT_DR : PORT_IF;
      resp_err_d   = !addr_ok;
    end
  end

  // State and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_DR;
      resp_owner_q <= PORT_IF;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      resp_owner_q <= resp_owner_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Response routing; reset masks a response registered just before it
  always_comb begin
    resp_valid = !rst && (state_q == RESP);
    if_rvalid  = resp_valid && (resp_owner_q == PORT_IF);
    dr_rvalid  = resp_valid && (resp_owner_q == PORT_DR);
    if_err     = if_rvalid && resp_err_q;
    dr_err     = dr_rvalid && resp_err_q;
    if_rdata   = (if_rvalid && !resp_err_q) ? rom_dout : '0;
    dr_rdata   = (dr_rvalid && !resp_err_q) ? rom_dout : '0;
  end

endmodule
